// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with programmable response latency; one outstanding
// request, single-cycle response strobe, sticky flag for requests issued while busy.

module dmem_lane #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wbyte,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [DEPTH_WORDS];

  // array is deliberately left out of reset
  always_ff @(posedge clk)
    if (go && we) mem[idx] <= wbyte;

  // nonblocking read of mem gives the pre-write byte on a read+write access
  always_ff @(posedge clk or posedge rst)
    if (rst) rbyte <= '0;
    else     rbyte <= (go && re) ? mem[idx] : '0;
endmodule

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              proto_err
);
  localparam int NUM_LANES = 4;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state, nxt;
  logic [CW-1:0] cnt;
  logic          req, accept, go;

  logic [AW-1:0]               lat_idx, acc_idx;
  logic [NUM_LANES-1:0]        lat_rmask, lat_wmask, acc_rmask, acc_wmask;
  logic [NUM_LANES-1:0][7:0]   lat_wdata, acc_wdata, rd;

  logic unused_addr;
  assign unused_addr = ^{bus.dmem_addr[31:AW+2], bus.dmem_addr[1:0]};

  assign req    = (|bus.dmem_rmask) | (|bus.dmem_wmask);
  assign accept = req && (state != S_BUSY);

  always_comb begin
    nxt = S_IDLE;
    if (state == S_BUSY)
      nxt = (cnt == CW'(1)) ? S_RESP : S_BUSY;
    else if (accept)
      nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
  end

  assign go = (nxt == S_RESP) && !rst;

  // with LATENCY=1 the access happens on the accept edge, straight from the bus
  assign acc_idx   = accept ? bus.dmem_addr[2 +: AW] : lat_idx;
  assign acc_rmask = accept ? bus.dmem_rmask         : lat_rmask;
  assign acc_wmask = accept ? bus.dmem_wmask         : lat_wmask;
  assign acc_wdata = accept ? bus.dmem_wdata         : lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lat_idx       <= '0;
      lat_rmask     <= '0;
      lat_wmask     <= '0;
      lat_wdata     <= '0;
      bus.dmem_resp <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      state         <= nxt;
      bus.dmem_resp <= go;
      if (state == S_BUSY && req) proto_err <= 1'b1;
      if (accept) begin
        cnt       <= CW'(LATENCY - 1);
        lat_idx   <= bus.dmem_addr[2 +: AW];
        lat_rmask <= bus.dmem_rmask;
        lat_wmask <= bus.dmem_wmask;
        lat_wdata <= bus.dmem_wdata;
      end else if (state == S_BUSY) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dmem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .re    (acc_rmask[i]),
        .we    (acc_wmask[i]),
        .idx   (acc_idx),
        .wbyte (acc_wdata[i]),
        .rbyte (rd[i])
      );
    end
  endgenerate

  assign bus.dmem_rdata = rd;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256): stimulus pushes
// expected (cycle, rdata) pairs, a negedge monitor pops and compares on each response.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t sb[$];

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every response must match the head of the scoreboard, in the right cycle
  always @(negedge clk) begin
    exp_t e;
    if (bus.dmem_resp === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
        check("resp_rdata", bus.dmem_rdata, e.data);
      end
    end else begin
      check("idle_rdata_zero", bus.dmem_rdata, 32'h0);
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("missing_resp", 32'(cyc), 32'hFFFF_FFFF);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input bit push, input logic [31:0] exp);
    exp_t e;
    bus.dmem_addr  = a;
    bus.dmem_rmask = rm;
    bus.dmem_wmask = wm;
    bus.dmem_wdata = wd;
    if (push) begin
      e.cyc  = cyc + LAT;
      e.data = exp;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    bus.dmem_wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dmem_addr  = 32'h0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    bus.dmem_wdata = 32'h0;
    #1;
    check("rst_resp",      {31'h0, bus.dmem_resp}, 32'h0);
    check("rst_rdata",     bus.dmem_rdata,         32'h0);
    check("rst_proto_err", {31'h0, proto_err},     32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_resp", {31'h0, bus.dmem_resp}, 32'h0);

    // full write then read, chained in the RESP cycle
    issue(32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1, 32'h0);       idle(1);
    issue(32'h10, 4'hF, 4'h0, 32'h0,        1, 32'hDEADBEEF); idle(1);
    // partial write lanes 0,2, partial read lanes 0,1, full read
    issue(32'h10, 4'h0, 4'b0101, 32'h11223344, 1, 32'h0);    idle(1);
    issue(32'h10, 4'b0011, 4'h0, 32'h0, 1, 32'h0000BE44);    idle(1);
    issue(32'h10, 4'hF, 4'h0, 32'h0,    1, 32'hDE22BE44);    idle(1);
    // read-before-write on a combined access
    issue(32'h20, 4'h0, 4'hF, 32'h12345678, 1, 32'h0);       idle(1);
    issue(32'h20, 4'hF, 4'hF, 32'hCAFEF00D, 1, 32'h12345678); idle(1);
    issue(32'h20, 4'hF, 4'h0, 32'h0,        1, 32'hCAFEF00D); idle(1);
    // high lane only, byte address low bits ignored
    issue(32'h23, 4'b1000, 4'h0, 32'h0,     1, 32'hCA000000); idle(1);
    // address wrap at 256 words
    issue(32'h400, 4'h0, 4'hF, 32'hA5A5A5A5, 1, 32'h0);      idle(1);
    issue(32'h0,   4'hF, 4'h0, 32'h0,        1, 32'hA5A5A5A5); idle(1);
    // prior contents for the reset-abort check
    issue(32'h8,   4'h0, 4'hF, 32'h0BADF00D, 1, 32'h0);      idle(LAT + 1);

    // violation: request in BUSY is dropped and flags proto_err
    check("no_err_before", {31'h0, proto_err}, 32'h0);
    issue(32'h30, 4'h0, 4'hF, 32'h55AA55AA, 1, 32'h0);
    issue(32'h10, 4'hF, 4'h0, 32'h0,        0, 32'h0);
    check("proto_err_set", {31'h0, proto_err}, 32'h1);
    idle(3);
    check("proto_err_sticky", {31'h0, proto_err}, 32'h1);

    // reset in BUSY aborts the pending write and clears outputs asynchronously
    issue(32'h8, 4'h0, 4'hF, 32'hFFFFFFFF, 0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("abort_resp",      {31'h0, bus.dmem_resp}, 32'h0);
    check("abort_rdata",     bus.dmem_rdata,         32'h0);
    check("abort_proto_err", {31'h0, proto_err},     32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_abort_err", {31'h0, proto_err}, 32'h0);
    issue(32'h8, 4'hF, 4'h0, 32'h0, 1, 32'h0BADF00D);        idle(LAT + 2);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
